abro_event_arbiter: RTL
=======================

// Module: abro_event_arbiter
// PURPOSE
//   Multi-channel ABRO controller: N_CH independent A-then-B detectors, each restartable by its own R.
//   Completed channels raise a pending request; a round-robin scheduler shares one registered event port
//   (valid/ready) among them and re-arms each channel when it is granted.
//   Sits between raw A/B/R event sources and the downstream event consumer.
// PARAMETERS
//   N_CH   4    number of ABRO channels (>=2)
//   CNT_W  16   width of accepted-event counter
//   ID_W   $clog2(N_CH)   derived localparam, channel index width
// PORTS
//   clk        in   1           rising-edge clock
//   reset      in   1           synchronous, active-low reset
//   a          in   N_CH        per-channel A event, sampled each cycle
//   b          in   N_CH        per-channel B event
//   r          in   N_CH        per-channel restart (R), highest priority
//   evt_valid  out  1           event present on evt_id
//   evt_ready  in   1           consumer accepts when evt_valid && evt_ready
//   evt_id     out  ID_W        index of completed channel
//   evt_count  out  CNT_W       total accepted events, wraps modulo 2^CNT_W
//   ch_state   out  2*N_CH      per-channel state, ch i at [2i+1:2i]
// BEHAVIOUR
//   Channel states (2-bit): WAIT=0, GOT_A=1, GOT_B=2, DONE=3. All registered.
//   Default: WAIT --a--> GOT_A --b--> DONE. a&&b in WAIT -> GOT_A (b ignored). GOT_B unreachable.
//   DONE holds (a,b ignored) until granted; grant moves it to WAIT next cycle.
//   r[i]=1: channel -> WAIT next cycle from any state; overrides a/b and the grant (r masks the request).
//   Output stage is a register. Load allowed when !evt_valid || evt_ready.
//   On load: scan requests (state==DONE && !r) round-robin starting at last_grant+1; winner -> evt_id,
//   evt_valid=1, winner channel -> WAIT. No request -> evt_valid=0 (if it was accepted).
//   evt_valid/evt_id stable while evt_valid && !evt_ready; r on an already-loaded channel does not retract it.
//   Back-to-back: accept and next load in the same cycle -> one event per cycle throughput.
//   Latency: b in GOT_A at cycle t -> DONE at t+1 -> evt_valid at t+2 if output free.
//   evt_count += 1 on each valid&&ready cycle; 2^CNT_W-1 wraps to 0.
//   Reset (reset==0 at posedge): all channels WAIT, evt_valid=0, evt_id=0, evt_count=0,
//   last_grant=N_CH-1 so channel 0 wins first. Reset mid-handshake drops the pending event.
// CONFIGURATION
//   ABRO_ANY_ORDER_EN defined: true ABRO semantics, A and B in any order.
//     WAIT --a&!b--> GOT_A, --b&!a--> GOT_B, --a&b--> DONE; GOT_A --b--> DONE; GOT_B --a--> DONE.
//   Undefined: strict A-then-B as above; GOT_B never entered.
// STRUCTURE
//   abro_pkg: typedef enum logic [1:0] abro_state_t {WAIT,GOT_A,GOT_B,DONE}.
//   Sub-module abro_channel (clk, reset, a, b, r, grant, state), instantiated N_CH times via generate.
//   Top holds round-robin pointer, output register, counter.
// TESTING
//   1 ch0: a@c1, b@c3, evt_ready=1 -> evt_valid=1,evt_id=0 at c5; ch_state[1:0]: 1@c2,3@c4,0@c5; evt_count=1.
//   2 ch1,ch2 DONE together, ready=1 -> evt_id 1 then 2 on consecutive cycles; repeat -> order starts after 2.
//   3 evt_ready=0 for 5 cycles with event held -> evt_valid,evt_id stable; count unchanged; other DONE waits.
//   4 a&&b same cycle on ch3 from WAIT -> GOT_A (default); DONE next cycle with ABRO_ANY_ORDER_EN.
//   5 r[0] while ch0 DONE -> ch0 WAIT, no event issued; r same cycle as a -> stays WAIT.
//   6 preload evt_count=0xFFFF via 65535 accepts then one more -> 0x0000; reset low mid-valid -> all zero.

Source files
------------

// File: rtl/abro_pkg.sv
// Shared types for the multi-channel ABRO event arbiter.
// Channel state encoding is visible on the ch_state output, so the values are fixed.
package abro_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    GOT_A = 2'd1,
    GOT_B = 2'd2,
    DONE  = 2'd3
  } abro_state_t;

  localparam int N_CH_DEFAULT  = 4;
  localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/abro_event_arbiter_if.sv
// Registered event port (valid/ready plus channel id) shared by all ABRO channels.
interface abro_event_arbiter_if #(
  parameter int ID_W = 2
) ();

  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);

endinterface

// File: rtl/abro_channel.sv
// One ABRO detector: waits for A then B (or either order when ABRO_ANY_ORDER_EN is
// defined), holds DONE until granted, and is forced back to WAIT by r at any time.
module abro_channel
  import abro_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        a,
  input  logic        b,
  input  logic        r,
  input  logic        grant,
  output abro_state_t state
);

  abro_state_t state_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= WAIT;
    end else begin
      state <= state_next;
    end
  end

  // r wins over everything, including a grant arriving in the same cycle.
  always_comb begin
    state_next = state;
    if (r) begin
      state_next = WAIT;
    end else begin
      case (state)
        WAIT: begin
`ifdef ABRO_ANY_ORDER_EN
          if (a && b)  state_next = DONE;
          else if (a)  state_next = GOT_A;
          else if (b)  state_next = GOT_B;
`else
          if (a)       state_next = GOT_A;
`endif
        end
        GOT_A: begin
          if (b)       state_next = DONE;
        end
        GOT_B: begin
`ifdef ABRO_ANY_ORDER_EN
          if (a)       state_next = DONE;
`else
          state_next = WAIT;
`endif
        end
        DONE: begin
          if (grant)   state_next = WAIT;
        end
        default:       state_next = WAIT;
      endcase
    end
  end

endmodule

// File: rtl/abro_event_arbiter.sv
// N_CH ABRO channels sharing one registered valid/ready event port via round-robin.
// Build with ABRO_ANY_ORDER_EN defined for any-order A/B detection in every channel.
module abro_event_arbiter
  import abro_pkg::*;
#(
  parameter int N_CH  = N_CH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  localparam int ID_W = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      a,
  input  logic [N_CH-1:0]      b,
  input  logic [N_CH-1:0]      r,
  abro_event_arbiter_if.master evt,
  output logic [CNT_W-1:0]     evt_count,
  output logic [2*N_CH-1:0]    ch_state
);

  abro_state_t     ch_st [N_CH];
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] grant;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            load_en;
  logic            out_valid;
  logic [ID_W-1:0] out_id;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    abro_channel u_ch (
      .clk   (clk),
      .reset (reset),
      .a     (a[i]),
      .b     (b[i]),
      .r     (r[i]),
      .grant (grant[i]),
      .state (ch_st[i])
    );
    assign req[i]            = (ch_st[i] == DONE) && !r[i];
    assign grant[i]          = load_en && found && (winner == ID_W'(i));
    assign ch_state[2*i +: 2] = ch_st[i];
  end

  assign load_en = !out_valid || evt.evt_ready;

  // Scan starts one past the last winner so every pending channel gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    idx    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = ID_W'((int'(last_grant) + k) % N_CH);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_id     <= '0;
      last_grant <= ID_W'(N_CH - 1);
      evt_count  <= '0;
    end else begin
      if (out_valid && evt.evt_ready) begin
        evt_count <= evt_count + CNT_W'(1);
      end
      if (load_en) begin
        out_valid <= found;
        if (found) begin
          out_id     <= winner;
          last_grant <= winner;
        end
      end
    end
  end

  assign evt.evt_valid = out_valid;
  assign evt.evt_id    = out_id;

endmodule
